// File: rtl/conv_pkg.sv
// Shared types and constants for the OFM output stage.
// Build option OFM_RELU_EN selects unsigned ReLU saturation (0..255) instead of signed int8.
package conv_pkg;

   localparam int BYTES_PER_WORD = 8;

`ifdef OFM_RELU_EN
   localparam int Q_MAX = 255;
   localparam int Q_MIN = 0;
`else
   localparam int Q_MAX = 127;
   localparam int Q_MIN = -128;
`endif

   typedef struct packed {
      logic                          last;
      logic [BYTES_PER_WORD-1:0]     keep;
      logic [8*BYTES_PER_WORD-1:0]   data;
   } ofm_entry_t;

   // Low-order byte mask covering n bytes (n = 0..8).
   function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [3:0] n);
      logic [8:0] m;
      m = (9'd1 << n) - 9'd1;
      return m[BYTES_PER_WORD-1:0];
   endfunction

endpackage

// File: rtl/ofm_fifo.sv
// Show-ahead synchronous FIFO with async-reset pointers; read data is valid whenever !empty.
module ofm_fifo #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Extra pointer MSB distinguishes full from empty when the slot indices match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/ofm_packer.sv
// Requantizes the two CONV_ACC result streams to bytes, packs them into 64-bit words and
// buffers them behind a valid/ready stream. Build option: OFM_RELU_EN (ReLU + unsigned saturation).
module ofm_packer
   import conv_pkg::*;
#(
   parameter int OUT_DATA_WIDTH = 25,
   parameter int FIFO_DEPTH     = 16,
   parameter int FIFO_AW        = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start_conv,
   input  logic [4:0]                       cfg_shift,
   input  logic signed [OUT_DATA_WIDTH-1:0] ofm_port0,
   input  logic signed [OUT_DATA_WIDTH-1:0] ofm_port1,
   input  logic                             ofm_port0_v,
   input  logic                             ofm_port1_v,
   input  logic                             end_conv,
   output logic [63:0]                      m_data,
   output logic [7:0]                       m_keep,
   output logic                             m_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             overflow,
   output logic                             busy
);

   localparam logic signed [OUT_DATA_WIDTH-1:0] Q_MAX_W = OUT_DATA_WIDTH'(Q_MAX);
   localparam logic signed [OUT_DATA_WIDTH-1:0] Q_MIN_W = OUT_DATA_WIDTH'(Q_MIN);

   logic [4:0]                     shift_q;
   logic [1:0][OUT_DATA_WIDTH-1:0] port_val;
   logic [1:0]                     port_v;
   logic [1:0][7:0]                q_byte_next;
   logic [1:0][7:0]                q_byte_reg;
   logic [1:0]                     q_v_reg;
   logic                           end_q_reg;
   logic                           pend_reg;
   logic                           pend_next;
   logic [3:0]                     cnt_reg;
   logic [3:0]                     cnt_next;
   logic [63:0]                    acc_reg;
   logic [63:0]                    acc_next;

   assign port_val = {ofm_port1, ofm_port0};
   assign port_v   = {ofm_port1_v, ofm_port0_v};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_quant
         logic signed [OUT_DATA_WIDTH-1:0] shifted;
         assign shifted = $signed(port_val[gi]) >>> shift_q;
         assign q_byte_next[gi] = (shifted > Q_MAX_W) ? Q_MAX_W[7:0] :
                                  (shifted < Q_MIN_W) ? Q_MIN_W[7:0] : shifted[7:0];
      end
   endgenerate

   logic [63:0] word;
   logic [63:0] full_word;
   logic [3:0]  c;
   logic        full_push;
   logic        end_eff;
   logic        push_req;
   logic        term;
   ofm_entry_t  push_entry;

   // Port0 is visited first so it lands in the lower byte when both are valid.
   always_comb begin
      word      = acc_reg;
      c         = cnt_reg;
      full_word = '0;
      full_push = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (q_v_reg[i]) begin
            word[8*c[2:0] +: 8] = q_byte_reg[i];
            c = c + 4'd1;
            if (c == 4'd8) begin
               full_word = word;
               full_push = 1'b1;
               word      = '0;
               c         = '0;
            end
         end
      end

      end_eff    = end_q_reg | pend_reg;
      push_req   = 1'b0;
      push_entry = '0;
      term       = 1'b0;
      pend_next  = 1'b0;
      acc_next   = word;
      cnt_next   = c;
      if (full_push) begin
         push_req        = 1'b1;
         push_entry.data = full_word;
         push_entry.keep = 8'hFF;
         push_entry.last = end_eff && (c == 4'd0);
         term            = end_eff && (c == 4'd0);
         // A leftover byte after a full word at end-of-stream is flushed on the next cycle.
         pend_next       = end_eff && (c != 4'd0);
      end else if (end_eff) begin
         push_req        = 1'b1;
         push_entry.data = word;
         push_entry.keep = keep_mask(c);
         push_entry.last = 1'b1;
         term            = 1'b1;
         acc_next        = '0;
         cnt_next        = '0;
      end
   end

   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   logic       wr_en;
   ofm_entry_t rd_entry;

   assign pop   = m_ready & ~fifo_empty;
   assign wr_en = push_req & ~start_conv & (~fifo_full | pop);

   ofm_fifo #(
      .WIDTH ($bits(ofm_entry_t)),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (push_entry),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         q_byte_reg <= '0;
         q_v_reg    <= '0;
         end_q_reg  <= 1'b0;
         pend_reg   <= 1'b0;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else if (start_conv) begin
         shift_q    <= cfg_shift;
         q_v_reg    <= '0;
         end_q_reg  <= 1'b0;
         pend_reg   <= 1'b0;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         q_byte_reg <= q_byte_next;
         q_v_reg    <= port_v;
         end_q_reg  <= end_conv;
         pend_reg   <= pend_next;
         cnt_reg    <= cnt_next;
         acc_reg    <= acc_next;
         if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
         if (term)
            busy <= 1'b0;
      end
   end

   assign m_valid = ~fifo_empty;
   assign m_data  = fifo_empty ? 64'd0 : rd_entry.data;
   assign m_keep  = fifo_empty ? 8'd0  : rd_entry.keep;
   assign m_last  = fifo_empty ? 1'b0  : rd_entry.last;

endmodule

// File: tb/tb_ofm_packer.sv
// Scoreboard bench for ofm_packer: a byte-queue reference model predicts words, a monitor checks pops.
module tb_ofm_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_conv = 1'b0;
   logic [4:0]  cfg_shift = '0;
   logic [24:0] ofm_port0 = '0;
   logic [24:0] ofm_port1 = '0;
   logic        ofm_port0_v = 1'b0;
   logic        ofm_port1_v = 1'b0;
   logic        end_conv = 1'b0;
   logic [63:0] m_data;
   logic [7:0]  m_keep;
   logic        m_last;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        overflow;
   logic        busy;

   ofm_packer #(.OUT_DATA_WIDTH(25), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .cfg_shift(cfg_shift),
      .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
      .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v), .end_conv(end_conv),
      .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  byte_q[$];
   int          shift_m = 0;
   bit          block_m = 1'b0;
   bit          exp_ovf = 1'b0;
   bit          ready_rand = 1'b0;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference quantizer: plain integer shift, then clamp to the output byte range.
   function automatic logic [7:0] quant(input logic [24:0] raw);
      int v;
      logic [31:0] u;
      v = int'($signed(raw)) >>> shift_m;
`ifdef OFM_RELU_EN
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
`else
      if (v < -128) v = -128;
      if (v > 127)  v = 127;
`endif
      u = v;
      return u[7:0];
   endfunction

   task automatic emit(input int n, input bit last);
      exp_t e;
      e.data = '0;
      e.keep = '0;
      e.last = last;
      for (int k = 0; k < n; k++) begin
         e.data[8*k +: 8] = byte_q.pop_front();
         e.keep[k] = 1'b1;
      end
      if (block_m && exp_q.size() >= 16) exp_ovf = 1'b1;
      else exp_q.push_back(e);
   endtask

   task automatic drive(input bit v0, input int p0, input bit v1, input int p1, input bit e);
      bit full;
      ofm_port0   = 25'(p0);
      ofm_port1   = 25'(p1);
      ofm_port0_v = v0;
      ofm_port1_v = v1;
      end_conv    = e;
      if (ready_rand) m_ready = 1'($urandom_range(0, 1));
      if (v0) byte_q.push_back(quant(ofm_port0));
      if (v1) byte_q.push_back(quant(ofm_port1));
      full = 1'b0;
      if (byte_q.size() >= 8) begin
         full = 1'b1;
         emit(8, e && (byte_q.size() == 8));
      end
      if (e && (!full || byte_q.size() > 0)) emit(byte_q.size(), 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic start(input int s);
      start_conv  = 1'b1;
      cfg_shift   = 5'(s);
      ofm_port0_v = 1'b0;
      ofm_port1_v = 1'b0;
      end_conv    = 1'b0;
      shift_m     = s;
      byte_q.delete();
      @(posedge clk);
      #1;
      start_conv = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      ready_rand = 1'b0;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || m_valid) && guard < 400) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 400) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
      end
   endtask

   function automatic int rnd_val();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 1200)) - 600;
      return int'($urandom);
   endfunction

   // Monitor: every handshake pops the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word actual=%h required=none", m_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("[TB] word data=%h keep=%h last=%0d", m_data, m_keep, m_last);
            check("m_data", m_data, e.data);
            check("m_keep", 64'(m_keep), 64'(e.keep));
            check("m_last", 64'(m_last), 64'(e.last));
         end
      end
   end

   initial begin
      // Reset state
      #1;
      check("rst_m_data", m_data, 64'd0);
      check("rst_m_keep", 64'(m_keep), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Port0 alone 1..8: latency, full word, then later end_conv gives an empty terminator
      start(0);
      check("busy_after_start", 64'(busy), 64'd1);
      m_ready = 1'b0;
      for (int k = 1; k <= 8; k++) drive(1'b1, k, 1'b0, 0, 1'b0);
      check("m_valid_t1", 64'(m_valid), 64'd0);
      idle(1);
      check("m_valid_t2", 64'(m_valid), 64'd1);
      check("word1_data", m_data, 64'h0807060504030201);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      idle(1);
      check("busy_after_flush", 64'(busy), 64'd0);
      drain();

      // Both ports, saturation
      start(0);
      drive(1'b1, 300, 1'b1, -3, 1'b0);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      idle(2);
      start(2);
      drive(1'b1, 1000, 1'b1, -1000, 1'b1);
      idle(2);
      drain();

      // Port1 alone, five bytes then end
      start(0);
      for (int k = 0; k < 5; k++) drive(1'b0, 0, 1'b1, 10 + k, 1'b0);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      idle(2);
      // Six bytes, then two with end: full word carries last
      start(0);
      for (int k = 0; k < 6; k++) drive(1'b1, 20 + k, 1'b0, 0, 1'b0);
      drive(1'b1, 40, 1'b1, 41, 1'b1);
      idle(2);
      // Seven bytes, then two with end: full word plus one-byte last word
      start(0);
      for (int k = 0; k < 7; k++) drive(1'b1, 50 + k, 1'b0, 0, 1'b0);
      drive(1'b1, 60, 1'b1, 61, 1'b1);
      idle(2);
      drain();

      // Overflow: 17 words with the consumer stalled
      start(0);
      m_ready = 1'b0;
      block_m = 1'b1;
      exp_ovf = 1'b0;
      for (int k = 0; k < 68; k++) drive(1'b1, 2 * k, 1'b1, 2 * k + 1, 1'b0);
      idle(3);
      check("overflow_set", 64'(overflow), 64'(exp_ovf));
      drain();
      block_m = 1'b0;
      check("overflow_sticky", 64'(overflow), 64'd1);
      start(0);
      check("overflow_cleared", 64'(overflow), 64'd0);

      // Randomized convolutions
      ready_rand = 1'b1;
      for (int cv = 0; cv < 8; cv++) begin
         int n;
         start(int'($urandom_range(0, 24)));
         n = int'($urandom_range(5, 40));
         for (int k = 0; k < n; k++)
            drive(1'($urandom_range(0, 1)), rnd_val(), 1'($urandom_range(0, 1)), rnd_val(), k == n - 1);
         idle(2);
      end
      drain();
      check("overflow_random", 64'(overflow), 64'd0);

      // Asynchronous reset mid-word with buffered words
      start(0);
      m_ready = 1'b0;
      for (int k = 0; k < 27; k++) drive(1'b1, k, 1'b0, 0, 1'b0);
      idle(2);
      check("m_valid_before_rst", 64'(m_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      byte_q.delete();
      check("arst_m_valid", 64'(m_valid), 64'd0);
      check("arst_m_data", m_data, 64'd0);
      check("arst_m_keep", 64'(m_keep), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      check("post_rst_m_valid", 64'(m_valid), 64'd0);
      check("post_rst_overflow", 64'(overflow), 64'd0);
      check("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
